// File: rtl/inst_queue_if.sv
// Enqueue/dequeue handshake bundle for the instruction queue.
// master: frontend/backend side; slave: the queue itself.
interface inst_queue_if;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [31:0] enq_inst;
    logic        enq_pred_taken;
    logic [31:0] enq_pred_target;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic        deq_pred_taken;
    logic [31:0] deq_pred_target;

    modport master (
        output enq_valid, enq_pc, enq_inst, enq_pred_taken, enq_pred_target, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_inst, deq_pred_taken, deq_pred_target
    );

    modport slave (
        input  enq_valid, enq_pc, enq_inst, enq_pred_taken, enq_pred_target, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_inst, deq_pred_taken, deq_pred_target
    );
endinterface

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with flush; define IQ_BYPASS_EN for a same-cycle
// enq-to-deq path when the queue is empty.
module inst_queue #(
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             backend_flush,
    inst_queue_if.slave      q,
    output logic [PTR_W:0]   occupancy
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

    entry_t         mem [DEPTH];
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;
    logic           empty, full;
    logic           enq_fire, deq_fire, wr_en, head_inc;
    entry_t         enq_entry, head_entry, out_entry;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);

    assign enq_entry  = '{pc: q.enq_pc, inst: q.enq_inst, pred_taken: q.enq_pred_taken,
                          pred_target: q.enq_pred_target};
    assign head_entry = mem[head_q[PTR_W-1:0]];

    assign q.enq_ready = !full;
    assign enq_fire    = q.enq_valid && !full && !backend_flush;
    assign occupancy   = tail_q - head_q;

`ifdef IQ_BYPASS_EN
    logic bypass;
    // An empty queue forwards the incoming instruction; if taken now it is never stored.
    assign bypass      = empty && q.enq_valid && !backend_flush;
    assign q.deq_valid = (!empty || q.enq_valid) && !backend_flush;
    assign out_entry   = empty ? enq_entry : head_entry;
    assign deq_fire    = q.deq_valid && q.deq_ready;
    assign wr_en       = enq_fire && !(bypass && q.deq_ready);
    assign head_inc    = deq_fire && !empty;
`else
    assign q.deq_valid = !empty && !backend_flush;
    assign out_entry   = head_entry;
    assign deq_fire    = q.deq_valid && q.deq_ready;
    assign wr_en       = enq_fire;
    assign head_inc    = deq_fire;
`endif

    assign q.deq_pc          = out_entry.pc;
    assign q.deq_inst        = out_entry.inst;
    assign q.deq_pred_taken  = out_entry.pred_taken;
    assign q.deq_pred_target = out_entry.pred_target;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (backend_flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (head_inc) head_d = head_q + PtrOne;
            if (wr_en)    tail_d = tail_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail_q[PTR_W-1:0]] <= enq_entry;
    end
endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush = 1'b0;
    logic [PTR_W:0] occupancy;
    int             n_cmp = 0;
    int             n_err = 0;
    ent_t           mq[$];

    inst_queue_if iq ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .backend_flush (flush),
        .q             (iq),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_enq(input bit v, input logic [31:0] pc);
        iq.enq_valid       = v;
        iq.enq_pc          = pc;
        iq.enq_inst        = $urandom;
        iq.enq_pred_taken  = 1'($urandom);
        iq.enq_pred_target = $urandom;
    endtask

    // Check outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        ent_t cur, exp_e;
        bit   exp_v, byp, enq_ok, deq_ok;
        @(negedge clk);
        cur = '{pc: iq.enq_pc, inst: iq.enq_inst, taken: iq.enq_pred_taken,
                target: iq.enq_pred_target};
        byp = 1'b0;
`ifdef IQ_BYPASS_EN
        byp = (mq.size() == 0) && iq.enq_valid && !flush && rst;
`endif
        exp_v = rst && !flush && (mq.size() > 0 || byp);
        check("deq_valid", 32'(iq.deq_valid), 32'(exp_v));
        check("enq_ready", 32'(iq.enq_ready), 32'(mq.size() < DEPTH));
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        if (exp_v) begin
            exp_e = (mq.size() == 0) ? cur : mq[0];
            check("deq_pc", iq.deq_pc, exp_e.pc);
            check("deq_inst", iq.deq_inst, exp_e.inst);
            check("deq_taken", 32'(iq.deq_pred_taken), 32'(exp_e.taken));
            check("deq_target", iq.deq_pred_target, exp_e.target);
        end
        if (!rst || flush) begin
            mq.delete();
        end else if (!(byp && iq.deq_ready)) begin
            enq_ok = iq.enq_valid && (mq.size() < DEPTH);
            deq_ok = exp_v && iq.deq_ready;
            if (deq_ok) void'(mq.pop_front());
            if (enq_ok) mq.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_enq(1'b0, 32'h0);
        iq.deq_ready = 1'b0;

        // Reset then idle
        repeat (2) cycle();
        rst = 1'b1;
        repeat (3) cycle();

        // Fill to full, then a refused 17th
        for (int i = 0; i < 16; i++) begin
            set_enq(1'b1, 32'h1000 + 32'(4 * i));
            cycle();
        end
        check("full_occ", 32'(occupancy), 32'd16);
        check("full_rdy", 32'(iq.enq_ready), 32'd0);
        set_enq(1'b1, 32'h1040);
        cycle();
        check("full_occ17", 32'(occupancy), 32'd16);

        // Drain 10, add 8 across the wrap, drain all in exact order
        set_enq(1'b0, 32'h0);
        iq.deq_ready = 1'b1;
        repeat (10) cycle();
        iq.deq_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_enq(1'b1, 32'h2000 + 32'(4 * i));
            cycle();
        end
        set_enq(1'b0, 32'h0);
        iq.deq_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            check("drain_pc", iq.deq_pc,
                  (i < 6) ? 32'h1028 + 32'(4 * i) : 32'h2000 + 32'(4 * (i - 6)));
            cycle();
        end
        cycle();

        // Steady-state simultaneous enq/deq at occupancy 5
        iq.deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_enq(1'b1, 32'h5000 + 32'(4 * i));
            cycle();
        end
        iq.deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_enq(1'b1, 32'h5014 + 32'(4 * i));
            #1;
            check("stream_pc", iq.deq_pc, 32'h5000 + 32'(4 * i));
            check("stream_occ", 32'(occupancy), 32'd5);
            cycle();
        end

        // Flush at occupancy 7 with concurrent enq/deq
        iq.deq_ready = 1'b0;
        repeat (2) begin
            set_enq(1'b1, $urandom);
            cycle();
        end
        check("pre_flush_occ", 32'(occupancy), 32'd7);
        flush = 1'b1;
        set_enq(1'b1, 32'h6000);
        iq.deq_ready = 1'b1;
        #1;
        check("flush_dv", 32'(iq.deq_valid), 32'd0);
        cycle();
        flush = 1'b0;
        iq.deq_ready = 1'b0;
        set_enq(1'b1, 32'h3000);
        check("post_flush_occ", 32'(occupancy), 32'd0);
        cycle();
        set_enq(1'b0, 32'h0);
        #1;
        check("refill_dv", 32'(iq.deq_valid), 32'd1);
        check("refill_pc", iq.deq_pc, 32'h3000);
        cycle();
        flush = 1'b1;
        set_enq(1'b1, 32'h7000);
        repeat (2) cycle();
        flush = 1'b0;
        check("b2b_flush_occ", 32'(occupancy), 32'd0);

        // Empty queue, enq with deq_ready: same-cycle only when bypass is built in
        set_enq(1'b1, 32'h4000);
        iq.deq_ready = 1'b1;
        #1;
`ifdef IQ_BYPASS_EN
        check("byp_dv", 32'(iq.deq_valid), 32'd1);
        check("byp_pc", iq.deq_pc, 32'h4000);
`else
        check("nobyp_dv", 32'(iq.deq_valid), 32'd0);
`endif
        cycle();
        set_enq(1'b0, 32'h0);
        iq.deq_ready = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_enq(($urandom_range(0, 3) != 0), $urandom);
            iq.deq_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset mid-operation
        iq.deq_ready = 1'b0;
        repeat (4) begin
            set_enq(1'b1, $urandom);
            cycle();
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_dv", 32'(iq.deq_valid), 32'd0);
        check("arst_rdy", 32'(iq.enq_ready), 32'd1);
        mq.delete();
        set_enq(1'b0, 32'h0);
        cycle();
        rst = 1'b1;
        set_enq(1'b1, 32'h8000);
        cycle();
        set_enq(1'b0, 32'h0);
        #1;
        check("arst_first_pc", iq.deq_pc, 32'h8000);
        iq.deq_ready = 1'b1;
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling FIFO between the fetch/predecode frontend and the backend decode (ID) stage.
- Stores one fetched instruction per entry with its PC and branch-prediction metadata.
- Presents entries in order to the backend's fifo consumer handshake.
- Discards all contents on backend_flush so the frontend can refill from the redirect PC.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), index width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; 0 = in reset.
- backend_flush  input  1  synchronous flush from the ROB.
- enq_valid  input  1  frontend has an instruction.
- enq_ready  output  1  queue accepts an enqueue this cycle.
- enq_pc  input  32  instruction PC.
- enq_inst  input  32  instruction word.
- enq_pred_taken  input  1  frontend predicted taken.
- enq_pred_target  input  32  predicted target PC.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  backend ID stage consumes the head.
- deq_pc  output  32  head PC.
- deq_inst  output  32  head instruction.
- deq_pred_taken  output  1  head prediction bit.
- deq_pred_target  output  32  head predicted target.
- occupancy  output  PTR_W+1  current entry count, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 97-bit array, plus head and tail pointers of PTR_W+1 bits (the extra wrap bit distinguishes full from empty).
  - empty = (head == tail).
  - full = (index bits equal, wrap bits differ).
  - Pointers increment modulo 2^(PTR_W+1); the index wraps from DEPTH-1 to 0.
- Reset (rst=0, asynchronous):
  - head = 0, tail = 0.
  - deq_valid = 0, occupancy = 0, enq_ready = 1 (the queue is empty).
  - Array contents are don't-care.
- enq_ready = !full. Value is based on registered state only; no combinational path from deq_ready.
- Enqueue fires when enq_valid && enq_ready && !backend_flush:
  - the entry is written at tail;
  - tail increments at the next edge.
- deq_valid = !empty && !backend_flush.
- deq_* outputs are a combinational read of the head entry.
  - They are don't-care when deq_valid = 0.
  - They hold stable while deq_valid && !deq_ready.
- Dequeue fires when deq_valid && deq_ready; head increments at the next edge.
- Simultaneous enqueue and dequeue (not full, not empty):
  - both fire;
  - occupancy is unchanged;
  - the written entry never aliases the read entry.
- Full queue: enq_ready = 0 even when a dequeue fires that cycle. The enqueue is accepted no earlier than the following cycle.
- Empty queue: an enqueue becomes visible at deq on the next cycle (1-cycle latency), unless IQ_BYPASS_EN is defined.
- backend_flush = 1:
  - at the next edge head = tail = 0 and occupancy = 0;
  - any concurrent enqueue or dequeue is ignored;
  - deq_valid is forced to 0 in the flush cycle.
  - Back-to-back flush cycles are legal, and each keeps the queue empty.
- occupancy = tail - head, computed in PTR_W+1 bits.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge. The first enqueue after reset release lands in entry 0.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - When empty && enq_valid && !backend_flush, deq_valid = 1 and deq_* = enq_* combinationally, in the same cycle.
  - If deq_ready = 1 in that cycle, the instruction is consumed and not stored: tail and head are unchanged.
  - If deq_ready = 0, it is stored normally.
- Undefined:
  - No enq-to-deq combinational path.
  - Minimum latency is 1 cycle, as described in Behaviour.

Test Plan:
- Reset then idle:
  - rst=0 for 2 cycles, then release;
  - expect deq_valid=0, enq_ready=1, occupancy=0 throughout.
- Fill to full with DEPTH=16:
  - enqueue PCs 0x1000, 0x1004, ... 0x103C with deq_ready=0;
  - expect occupancy=16 and enq_ready=0 after the 16th;
  - a 17th enq_valid is not accepted.
- In-order drain with wrap:
  - after the fill, dequeue 10;
  - enqueue 8 more (0x2000 up to 0x201C);
  - dequeue all;
  - expect PCs 0x1028..0x103C followed by 0x2000..0x201C, in exact order.
- Simultaneous enq/deq:
  - at occupancy=5, hold enq_valid=deq_ready=1 for 20 cycles;
  - expect occupancy to stay 5 and the output PC sequence to stay contiguous.
- Flush mid-stream:
  - at occupancy=7, assert backend_flush together with enq_valid and deq_ready;
  - expect deq_valid=0 in that cycle and occupancy=0 next cycle;
  - the next enqueue, PC 0x3000, appears at deq one cycle later (no bypass).
- Bypass, with IQ_BYPASS_EN defined:
  - on an empty queue, enq PC 0x4000 with deq_ready=1;
  - expect deq_valid=1 and deq_pc=0x4000 in the same cycle, with occupancy remaining 0.
